// File: rtl/vga_pkg.sv
// ============================================================================
// Module : vga_pkg
// Brief  : Shared VGA display-path constants and helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int CW_DEFAULT = 4;

    localparam logic [11:0] KEY_MAGENTA = 12'hF0F;

    localparam int LAYER_BG     = 0;
    localparam int LAYER_MAP    = 1;
    localparam int LAYER_BOX    = 2;
    localparam int LAYER_PLAYER = 3;

    // Width of one packed {R,G,B} pixel for a given channel width.
    function automatic int rgb_w(input int cw);
        return 3 * cw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_sel.sv
// ============================================================================
// Module : prio_sel
// Brief  : Combinational highest-index-wins selector with any-hit flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prio_sel #(
    parameter int NUM = 4,
    parameter int DW  = 12
) (
    input  logic [NUM-1:0]    i_req,
    input  logic [NUM*DW-1:0] i_data,
    output logic [DW-1:0]     o_data,
    output logic              o_any_hit
);

    // Ascending scan: a later (higher) index overwrites any earlier hit.
    always_comb begin
        o_data    = '0;
        o_any_hit = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (i_req[i]) begin
                o_data    = i_data[i*DW +: DW];
                o_any_hit = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/layer_compositor.sv
// ============================================================================
// Module : layer_compositor
// Brief  : Two-stage priority layer compositor with frame-shadowed masks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module layer_compositor
    import vga_pkg::*;
#(
    parameter int              NUM_LAYERS = 4,
    parameter int              CW         = CW_DEFAULT,
    parameter logic [3*CW-1:0] KEY_RGB    = KEY_MAGENTA,
    parameter int              BLINK_LOG2 = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          de_in,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic [NUM_LAYERS-1:0]         layer_rq,
    input  logic [NUM_LAYERS*3*CW-1:0]    layer_rgb,
    input  logic [3*CW-1:0]               bg_rgb,
    input  logic                          cfg_we,
    input  logic [NUM_LAYERS-1:0]         cfg_en_mask,
    input  logic [NUM_LAYERS-1:0]         cfg_blink_mask,
    input  logic                          key_en,
    output logic [3*CW-1:0]               rgb_out,
    output logic                          de_out,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic [7:0]                    frame_cnt
);

    localparam int PW = rgb_w(CW);

    logic [NUM_LAYERS-1:0]    r_en_pend;
    logic [NUM_LAYERS-1:0]    r_blink_pend;
    logic [NUM_LAYERS-1:0]    r_en_act;
    logic [NUM_LAYERS-1:0]    r_blink_act;

    logic [NUM_LAYERS-1:0]    r_eff_s1;
    logic [NUM_LAYERS*PW-1:0] r_rgb_s1;
    logic [PW-1:0]            r_bg_s1;
    logic                     r_de_s1;
    logic                     r_hs_s1;
    logic                     r_vs_s1;

    logic                     w_vs_rise;
    logic                     w_blink_off;
    logic [NUM_LAYERS-1:0]    w_eff;
    logic [PW-1:0]            w_sel_rgb;
    logic                     w_any_hit;

    // Stage-1 vsync register doubles as the edge detector's history.
    assign w_vs_rise   = vsync_in & ~r_vs_s1;
    assign w_blink_off = frame_cnt[BLINK_LOG2-1];

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_eff
            logic w_keyed;
            assign w_keyed   = key_en && (layer_rgb[gi*PW +: PW] == KEY_RGB);
            assign w_eff[gi] = layer_rq[gi] & r_en_act[gi]
                             & ~(r_blink_act[gi] & w_blink_off) & ~w_keyed;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_pend    <= '1;
            r_blink_pend <= '0;
            r_en_act     <= '1;
            r_blink_act  <= '0;
            frame_cnt    <= 8'd0;
        end else begin
            if (cfg_we) begin
                r_en_pend    <= cfg_en_mask;
                r_blink_pend <= cfg_blink_mask;
            end
            if (w_vs_rise) begin
                // A write landing on the boundary goes straight to the active set.
                r_en_act    <= cfg_we ? cfg_en_mask    : r_en_pend;
                r_blink_act <= cfg_we ? cfg_blink_mask : r_blink_pend;
                frame_cnt   <= frame_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eff_s1 <= '0;
            r_rgb_s1 <= '0;
            r_bg_s1  <= '0;
            r_de_s1  <= 1'b0;
            r_hs_s1  <= 1'b0;
            r_vs_s1  <= 1'b0;
        end else begin
            r_eff_s1 <= w_eff;
            r_rgb_s1 <= layer_rgb;
            r_bg_s1  <= bg_rgb;
            r_de_s1  <= de_in;
            r_hs_s1  <= hsync_in;
            r_vs_s1  <= vsync_in;
        end
    end

    prio_sel #(
        .NUM (NUM_LAYERS),
        .DW  (PW)
    ) u_prio_sel (
        .i_req     (r_eff_s1),
        .i_data    (r_rgb_s1),
        .o_data    (w_sel_rgb),
        .o_any_hit (w_any_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out   <= '0;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            if (!r_de_s1)
                rgb_out <= '0;
            else if (w_any_hit)
                rgb_out <= w_sel_rgb;
            else
                rgb_out <= r_bg_s1;
            de_out    <= r_de_s1;
            hsync_out <= r_hs_s1;
            vsync_out <= r_vs_s1;
        end
    end

endmodule

`default_nettype wire
